// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-block, read-only instruction cache.
// Fetch requests hit combinationally from IDLE; a miss latches the word
// address and fetches it from the memory arbiter. The word is installed on
// the completion edge, and the request is then looked up again.
//
// Handshake: a memory read is requested while iREN is high, and iaddr holds
// stable for the whole request. The arbiter holds iwait high while busy. The
// first clock edge with iREN high and iwait low transfers iload. iREN drops
// in the cycle after that edge.
module icache #(
  parameter int INDEX_W = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t state;

  // Only valid bits are reset; tag/data are qualified by valid.
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  logic [31:0] miss_addr;
  logic        ren_q;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               lookup_hit;
  logic               fill_done;

  assign req_idx  = imemaddr[INDEX_W+1:2];
  assign req_tag  = imemaddr[31:INDEX_W+2];
  assign fill_idx = miss_addr[INDEX_W+1:2];
  assign fill_tag = miss_addr[31:INDEX_W+2];

  // A hit is only reported from IDLE, so a fetch in flight always stalls the datapath.
  assign lookup_hit = (state == IDLE) && imemREN && valid_q[req_idx] &&
                      (tag_q[req_idx] == req_tag);
  assign fill_done  = (state == FETCH) && !iwait;

  assign ihit     = lookup_hit;
  assign imemload = lookup_hit ? data_q[req_idx] : 32'h0;
  assign iREN     = ren_q;
  assign iaddr    = miss_addr;

  // Control FSM: miss detection, fetch tracking and valid-bit installation.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      valid_q   <= '0;
      miss_addr <= 32'h0;
      ren_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !lookup_hit) begin
            miss_addr <= {imemaddr[31:2], 2'b00};
            ren_q     <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            valid_q[fill_idx] <= 1'b1;
            ren_q             <= 1'b0;
            state             <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ren_q <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays: written on the fetch completion edge, never reset.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scenarios plus a randomized phase. A behavioural model
// keeps the resident word address per set, and a compare process checks every
// output on every negative clock edge.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b0;
  logic [31:0] iload = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  icache #(.INDEX_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, required finish before 400000");
    $fatal(1, "timeout");
  end

  // ---------------- shared check ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- memory / arbiter model ----------------
  logic [31:0] mem [int unsigned];
  int forced_wait = -1;
  int wait_left   = 0;
  bit in_fetch    = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Arbiter: a chosen number of busy cycles, then the word for iaddr.
  always @(posedge CLK) begin
    #1;
    if (iREN) begin
      if (!in_fetch) begin
        in_fetch  = 1;
        wait_left = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 3));
      end
      if (wait_left > 0) begin
        iwait = 1'b1;
        iload = $urandom;
        wait_left--;
      end else begin
        iwait = 1'b0;
        iload = mem_rd(iaddr);
        in_fetch = 0;
      end
    end else begin
      in_fetch = 0;
      iwait = 1'($urandom_range(0, 1));
      iload = $urandom;
    end
  end

  // ---------------- behavioural cache model ----------------
  bit          m_valid [16];
  logic [29:0] m_word  [16];
  logic [31:0] m_data  [16];
  bit          m_busy = 0;
  logic [31:0] m_fetch_addr = 32'h0;

  function automatic bit model_hit(input logic [31:0] a);
    int s;
    s = int'(a[31:2] % 16);
    return m_valid[s] && (m_word[s] == a[31:2]);
  endfunction

  // A reset empties the cache. Otherwise a pending fetch completes when the
  // arbiter is not busy, and a missing request starts a new fetch.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_busy = 0;
      m_fetch_addr = 32'h0;
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
    end else if (m_busy) begin
      if (!iwait) begin
        m_valid[m_fetch_addr[31:2] % 16] = 1;
        m_word[m_fetch_addr[31:2] % 16]  = m_fetch_addr[31:2];
        m_data[m_fetch_addr[31:2] % 16]  = iload;
        m_busy = 0;
      end
    end else if (imemREN && !model_hit(imemaddr)) begin
      m_busy = 1;
      m_fetch_addr = {imemaddr[31:2], 2'b00};
    end
  end

  // Compare process: all outputs every cycle.
  always @(negedge CLK) begin
    logic        e_hit;
    logic [31:0] e_load;
    e_hit  = !m_busy && imemREN && model_hit(imemaddr);
    e_load = e_hit ? m_data[imemaddr[31:2] % 16] : 32'h0;
    chk("ihit",     {31'h0, ihit}, {31'h0, e_hit});
    chk("imemload", imemload, e_load);
    chk("iREN",     {31'h0, iREN}, {31'h0, m_busy});
    chk("iaddr",    iaddr, m_fetch_addr);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [31:0] a);
    @(posedge CLK);
    #1;
    imemREN  = en;
    imemaddr = a;
  endtask

  // Waits for ihit on the current request (already driven).
  task automatic wait_hit(output bit hit0, output int ren_cycles,
                          output logic [31:0] first_iaddr, output logic [31:0] last_iaddr,
                          output logic [31:0] data);
    bit ok;
    ok = 0; hit0 = 0; ren_cycles = 0;
    first_iaddr = 32'hFFFF_FFFF; last_iaddr = 32'hFFFF_FFFF; data = 32'h0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (c == 0) hit0 = ihit;
      if (iREN) begin
        if (ren_cycles == 0) first_iaddr = iaddr;
        last_iaddr = iaddr;
        ren_cycles++;
      end
      if (ihit) begin
        data = imemload;
        ok = 1;
        break;
      end
      @(posedge CLK);
      #1;
    end
    chk("hit_within_budget", {31'h0, ok}, 32'h1);
  endtask

  task automatic access(input logic [31:0] a, output bit hit0, output int ren_cycles,
                        output logic [31:0] first_iaddr, output logic [31:0] data);
    logic [31:0] last;
    drive(1'b1, a);
    wait_hit(hit0, ren_cycles, first_iaddr, last, data);
  endtask

  // ---------------- sequencer ----------------
  initial begin
    bit          h0;
    int          rc;
    logic [31:0] fa, la, d;

    mem[32'h0]  = 32'h2402_0001;
    mem[32'h40] = 32'hDEAD_BEEF;

    // Reset state
    @(negedge CLK);
    chk("rst_iREN",     {31'h0, iREN}, 32'h0);
    chk("rst_iaddr",    iaddr, 32'h0);
    chk("rst_ihit",     {31'h0, ihit}, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    @(posedge CLK); #1; nRST = 1'b1;

    // Cold miss: three busy cycles, so four request cycles
    forced_wait = 3;
    access(32'h0, h0, rc, fa, d);
    chk("cold_first_hit", {31'h0, h0}, 32'h0);
    chk("cold_ren_cycles", rc, 4);
    chk("cold_iaddr", fa, 32'h0);
    chk("cold_data", d, 32'h2402_0001);

    // Warm hits on 0x0 and 0x3
    access(32'h0, h0, rc, fa, d);
    chk("warm0_hit", {31'h0, h0}, 32'h1);
    chk("warm0_ren", rc, 0);
    chk("warm0_data", d, 32'h2402_0001);
    access(32'h3, h0, rc, fa, d);
    chk("warm3_hit", {31'h0, h0}, 32'h1);
    chk("warm3_ren", rc, 0);
    chk("warm3_data", d, 32'h2402_0001);

    // Conflict in set 0, with no busy cycles: hit two cycles after the miss
    forced_wait = 0;
    access(32'h40, h0, rc, fa, d);
    chk("conf_miss", {31'h0, h0}, 32'h0);
    chk("conf_iaddr", fa, 32'h40);
    chk("conf_ren_cycles", rc, 1);
    chk("conf_data", d, 32'hDEAD_BEEF);
    access(32'h0, h0, rc, fa, d);
    chk("conf_back_miss", {31'h0, h0}, 32'h0);
    chk("conf_back_data", d, 32'h2402_0001);

    // Address change mid-fetch
    forced_wait = 3;
    drive(1'b1, 32'h104);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    imemaddr = 32'h200;
    @(negedge CLK);
    chk("midfetch_iaddr", iaddr, 32'h104);
    chk("midfetch_ihit", {31'h0, ihit}, 32'h0);
    @(posedge CLK); #1;
    wait_hit(h0, rc, fa, la, d);
    chk("midfetch_refetch_iaddr", la, 32'h200);
    chk("midfetch_data200", d, mem_rd(32'h200));
    access(32'h104, h0, rc, fa, d);
    chk("midfetch_set1_hit", {31'h0, h0}, 32'h1);
    chk("midfetch_set1_data", d, mem_rd(32'h104));

    // Reset mid-fetch
    forced_wait = 5;
    drive(1'b1, 32'h8);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rstmid_in_fetch", {31'h0, iREN}, 32'h1);
    @(posedge CLK); #1;
    nRST = 1'b0;
    @(negedge CLK);
    chk("rstmid_iREN", {31'h0, iREN}, 32'h0);
    chk("rstmid_ihit", {31'h0, ihit}, 32'h0);
    chk("rstmid_iaddr", iaddr, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    forced_wait = 1;
    wait_hit(h0, rc, fa, la, d);
    chk("rstmid_remiss", {31'h0, h0}, 32'h0);
    chk("rstmid_refetch_iaddr", fa, 32'h8);
    chk("rstmid_data", d, mem_rd(32'h8));

    // Fill all 16 sets, then reread them
    forced_wait = -1;
    for (int i = 0; i < 16; i++) access(32'(i * 4), h0, rc, fa, d);
    for (int i = 0; i < 16; i++) begin
      access(32'(i * 4), h0, rc, fa, d);
      chk("fill_reread_hit", {31'h0, h0}, 32'h1);
      chk("fill_reread_ren", rc, 0);
      chk("fill_reread_data", d, mem_rd(32'(i * 4)));
    end

    // Randomized traffic over a small address pool to force conflicts
    for (int n = 0; n < 1500; n++) begin
      drive(1'($urandom_range(0, 3) != 0),
            {22'h0, 8'($urandom_range(0, 47)), 2'($urandom_range(0, 3))});
    end
    drive(1'b0, 32'h0);
    repeat (10) @(posedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
